// File: rtl/cpu_mem_responder.sv
// Unified instruction/data word memory with a req/ready handshake and a fixed,
// parameterised number of wait states per access. Faults are reported via err.
module cpu_mem_responder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q;
  logic [WIDTH-1:0]     addr_q, wdata_q;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 access;
  logic                 mem_we;
  logic                 fault;
  logic [ADDR_BITS-1:0] index;

  logic [WIDTH-1:0] mem [2**ADDR_BITS];

  assign index = addr_q[ADDR_BITS+1:2];
  // Misaligned, or any address bit above the word-index field set.
  assign fault = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_BITS + 2)) != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StWait;
          cnt_d   = WaitLoad;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = StResp;
          ready_d = 1'b1;
          err_d   = fault;
          if (!we_q) begin
            rdata_d = fault ? '0 : mem[index];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // A reset on the committing edge must keep the pending write out of memory.
  assign mem_we = access && we_q && !fault && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      if (state_q == StIdle && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[index] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Unified instruction/data memory responder for the multicycle MIPS core. It serves the word accesses the control FSM issues for instruction fetch and for data, using a request/ready handshake. Each access takes a fixed, parameterised number of wait states, so the control FSM must hold in its fetch and memory states until `ready` is high. It sits between the datapath's memory-address mux (driven by the IorD select) and the register file / instruction register.

## Interface
- `WIDTH`, 32: data and address width.
- `ADDR_BITS`, 8: word-index width; memory depth is 2^ADDR_BITS words.
- `WAIT_CYCLES`, 2: number of extra wait states per access, from 0 to 15.
- `clk` input, 1 bit: single clock. All logic is rising-edge.
- `rst` input, 1 bit: reset. It is synchronous and active-high.
- `req` input, 1 bit: access request. It is sampled only in IDLE.
- `we` input, 1 bit: 1 = write, 0 = read. It is latched together with `req`.
- `addr` input, `WIDTH` bits: byte address. It is latched together with `req`.
- `wdata` input, `WIDTH` bits: write data. It is latched together with `req`.
- `rdata` output, `WIDTH` bits: read data. It is registered and holds its value until the next completed read.
- `ready` output, 1 bit: one-cycle completion pulse.
- `err` output, 1 bit: access fault. It is valid only while `ready` is high.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- The state machine has three states: IDLE, WAIT and RESP. A 4-bit down-counter `cnt` is used in WAIT.
- **IDLE**
  - If `req` is 1, latch `we`, `addr` and `wdata`, load `cnt` with WAIT_CYCLES and go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - If `cnt` is 0, perform the access and go to RESP.
  - Otherwise decrement `cnt`.
  - `req` is ignored in this state.
- **RESP**
  - `ready` is 1 for exactly this cycle.
  - The next state is always IDLE.
  - `req` is ignored in this state; the requester must deassert it or re-present it after RESP.
- **Address decode**
  - The word index is `addr[ADDR_BITS+1:2]`.
  - A fault exists if `addr[1:0]` is not 0 (misaligned), or if any bit of `addr[WIDTH-1:ADDR_BITS+2]` is not 0 (out of range).
- **Access, performed on the edge that enters RESP**
  - Write without fault: `mem[index] <= wdata`. `rdata` is unchanged.
  - Read without fault: `rdata <= mem[index]`.
  - Faulted write: memory is not modified and `rdata` is unchanged.
  - Faulted read: `rdata <= 0`.
  - On any fault, `err <= 1`.
- `ready` and `err` are registered outputs. Both are 0 outside RESP.
- Memory is a plain register array. It is not reset, and its contents are undefined until written.

## Timing
- **Reset values**: state = IDLE, `cnt` = 0, `ready` = 0, `err` = 0, `busy` = 0, `rdata` = 0.
- **Reset has priority** over every other transition in every state.
  - A reset asserted in WAIT abandons the pending access; a pending write never reaches memory.
  - A reset asserted in RESP clears `ready` and `err` on the same edge.
- **Latency**: the edge that accepts `req` is E. `ready` rises after edge E + WAIT_CYCLES + 1 and falls after edge E + WAIT_CYCLES + 2.
  - With WAIT_CYCLES = 0, `ready` is high in the second cycle after acceptance.
- **Throughput**: if `req` is held continuously, accept edges are WAIT_CYCLES + 3 edges apart.
- `busy` rises on the accept edge and falls on the edge that leaves RESP.
- **Read-after-write**: a read accepted after a write returns the new data. There is no bypass; the write has already committed on its RESP edge.
- Changes to `addr`, `wdata` or `we` after the accept edge have no effect on the access in progress.

## Test plan
- **Write then read**, WAIT_CYCLES = 2. Write `0xDEADBEEF` to address `0x10`, then read address `0x10`.
  - Required: `ready` pulses 3 cycles after each accept, `rdata` = `0xDEADBEEF`, `err` = 0.
- **Zero wait**, WAIT_CYCLES = 0. Issue back-to-back reads with `req` held at 1.
  - Required: `ready` pulses every 3 cycles and `busy` is low for exactly 1 cycle between accesses.
- **Faults**. Read address `0x13`, then read address `0x400` with ADDR_BITS = 8.
  - Required: both complete with `ready` = 1, `err` = 1 and `rdata` = 0.
  - Then write `0x55` to address `0x402`. Required: `err` = 1, and reading address `0x000` returns its previous value.
- **Request while busy**. Toggle `req` with a different `addr` during WAIT and RESP.
  - Required: no extra `ready` pulse, and the latched address is the one serviced.
- **Reset mid-write**. Accept a write of `0x12345678` to address `0x20`, then assert `rst` for 1 cycle in WAIT.
  - Required: outputs return to their reset values on the next edge, and a later read of `0x20` returns the prior value, not `0x12345678`.
- **rdata hold**. After a successful read returning `0xA5A5A5A5`, perform a write.
  - Required: `rdata` stays at `0xA5A5A5A5` through and after the write's RESP cycle.
